// File: rtl/obi_dram_bridge.sv
// obi_dram_bridge: connects the x_heep ext_core_data OBI master to the FPGA DRAM
// controller command/response channels. It decodes the DRAM window and holds one
// registered command. It allows at most MAX_OUTSTANDING granted, unanswered requests
// and returns responses in grant order. Accesses outside the window are answered
// locally with an error.
// Optional watchdog: define OBI_DRAM_BRIDGE_TIMEOUT_EN to enable it.
// Handshakes: a DRAM command transfers on a cycle with dram_cmd_valid_o && dram_cmd_ready_i;
// once valid is raised, the command fields hold until that transfer. DRAM responses have no
// backpressure. An OBI request transfers on a cycle with obi_req_i && obi_gnt_o.
module obi_dram_bridge #(
  parameter logic [31:0] BASE_ADDR       = 32'h4000_0000,
  parameter logic [31:0] WINDOW_SIZE     = 32'h1000_0000,
  parameter int unsigned MAX_OUTSTANDING = 4
`ifdef OBI_DRAM_BRIDGE_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
`endif
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        obi_req_i,
  input  logic [31:0] obi_addr_i,
  input  logic        obi_we_i,
  input  logic [3:0]  obi_be_i,
  input  logic [31:0] obi_wdata_i,
  output logic        obi_gnt_o,
  output logic        obi_rvalid_o,
  output logic [31:0] obi_rdata_o,
  output logic        obi_err_o,
  output logic        dram_cmd_valid_o,
  input  logic        dram_cmd_ready_i,
  output logic [31:0] dram_cmd_addr_o,
  output logic        dram_cmd_we_o,
  output logic [3:0]  dram_cmd_be_o,
  output logic [31:0] dram_cmd_wdata_o,
  input  logic        dram_rsp_valid_i,
  input  logic [31:0] dram_rsp_rdata_i,
  input  logic        dram_rsp_error_i,
  output logic        busy_o,
  output logic        timeout_o
);

  localparam int unsigned   PW          = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned   CW          = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] LP_MAX      = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LP_LAST     = PW'(MAX_OUTSTANDING - 1);
  localparam logic [31:0]   LP_ERR_DATA = 32'hDEAD_BEEF;

  // Order FIFO: one bit per granted request, 1 = answered locally with an error.
  logic [MAX_OUTSTANDING-1:0] r_fifo;
  logic [PW-1:0]              r_rd_ptr;
  logic [PW-1:0]              r_wr_ptr;
  logic [CW-1:0]              r_count;

  logic        r_cmd_valid;
  logic [31:0] r_cmd_addr;
  logic        r_cmd_we;
  logic [3:0]  r_cmd_be;
  logic [31:0] r_cmd_wdata;

  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [31:0] w_offset;
  logic        w_in_win;
  logic        w_cmd_free;
  logic        w_gnt;
  logic        w_head_local;
  logic        w_head_dram;
  logic        w_rsp_take;
  logic        w_timeout_fire;
  logic        w_retire;
  logic [31:0] w_rsp_rdata;
  logic        w_rsp_err;

  // Window decode as an unsigned offset compare; this avoids overflow of BASE+SIZE.
  assign w_offset   = obi_addr_i - BASE_ADDR;
  assign w_in_win   = (w_offset < WINDOW_SIZE);
  assign w_cmd_free = !r_cmd_valid || dram_cmd_ready_i;
  assign w_gnt      = rst_ni && obi_req_i && (r_count < LP_MAX) && (!w_in_win || w_cmd_free);

  assign w_head_local = (r_count != '0) && r_fifo[r_rd_ptr];
  assign w_head_dram  = (r_count != '0) && !r_fifo[r_rd_ptr];

`ifdef OBI_DRAM_BRIDGE_TIMEOUT_EN
  localparam logic [31:0] LP_TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] r_wd;
  logic [7:0]  r_drop;
  logic        r_timeout;
  logic        w_rsp_discard;

  // Responses that belong to timed-out entries are discarded first.
  assign w_rsp_discard  = dram_rsp_valid_i && (r_drop != '0);
  assign w_rsp_take     = dram_rsp_valid_i && (r_drop == '0) && w_head_dram;
  assign w_timeout_fire = w_head_dram && !w_rsp_take && (r_wd == LP_TO_LAST);
  assign timeout_o      = r_timeout;

  // Watchdog: counts cycles the DRAM head waits, flags a timeout and tracks late responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wd      <= '0;
      r_drop    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_retire || !w_head_dram) r_wd <= '0;
      else                          r_wd <= r_wd + 32'd1;
      if (w_timeout_fire) r_timeout <= 1'b1;
      if (w_timeout_fire && !w_rsp_discard)      r_drop <= r_drop + 8'd1;
      else if (!w_timeout_fire && w_rsp_discard) r_drop <= r_drop - 8'd1;
    end
  end
`else
  // A response arriving with no DRAM entry at the head is simply ignored.
  assign w_rsp_take     = dram_rsp_valid_i && w_head_dram;
  assign w_timeout_fire = 1'b0;
  assign timeout_o      = 1'b0;
`endif

  assign w_retire    = w_head_local || w_rsp_take || w_timeout_fire;
  assign w_rsp_rdata = w_rsp_take ? dram_rsp_rdata_i : LP_ERR_DATA;
  assign w_rsp_err   = w_rsp_take ? dram_rsp_error_i : 1'b1;

  // Order FIFO and outstanding count: push on grant, pop on retire.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fifo   <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_gnt) begin
        r_fifo[r_wr_ptr] <= !w_in_win;
        r_wr_ptr         <= (r_wr_ptr == LP_LAST) ? '0 : r_wr_ptr + PW'(1);
      end
      if (w_retire) r_rd_ptr <= (r_rd_ptr == LP_LAST) ? '0 : r_rd_ptr + PW'(1);
      if (w_gnt && !w_retire)      r_count <= r_count + CW'(1);
      else if (!w_gnt && w_retire) r_count <= r_count - CW'(1);
    end
  end

  // Command register: loads on an in-window grant and holds until DRAM accepts it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cmd_valid <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_we    <= 1'b0;
      r_cmd_be    <= '0;
      r_cmd_wdata <= '0;
    end else if (w_gnt && w_in_win) begin
      r_cmd_valid <= 1'b1;
      r_cmd_addr  <= w_offset;
      r_cmd_we    <= obi_we_i;
      r_cmd_be    <= obi_be_i;
      r_cmd_wdata <= obi_wdata_i;
    end else if (r_cmd_valid && dram_cmd_ready_i) begin
      r_cmd_valid <= 1'b0;
    end
  end

  // Response register: a single-cycle rvalid pulse per retired entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_retire;
      r_rdata  <= w_retire ? w_rsp_rdata : '0;
      r_err    <= w_retire && w_rsp_err;
    end
  end

  assign obi_gnt_o        = w_gnt;
  assign obi_rvalid_o     = r_rvalid;
  assign obi_rdata_o      = r_rdata;
  assign obi_err_o        = r_err;
  assign dram_cmd_valid_o = r_cmd_valid;
  assign dram_cmd_addr_o  = r_cmd_addr;
  assign dram_cmd_we_o    = r_cmd_we;
  assign dram_cmd_be_o    = r_cmd_be;
  assign dram_cmd_wdata_o = r_cmd_wdata;
  assign busy_o           = (r_count != '0) || r_cmd_valid;

endmodule

// File: tb/tb_obi_dram_bridge.sv
// Testbench for obi_dram_bridge. A randomized OBI master and a DRAM responder
// drive the bridge. A scoreboard predicts every OBI response and every DRAM
// command at grant time, and a separate monitor checks what the bridge presents.
`timescale 1ns/1ps
module tb_obi_dram_bridge;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] SIZE = 32'h1000_0000;
`ifdef OBI_DRAM_BRIDGE_TIMEOUT_EN
  localparam int TO = 16;
`endif

  logic        clk, rst_ni;
  logic        obi_req_i, obi_we_i;
  logic [31:0] obi_addr_i, obi_wdata_i;
  logic [3:0]  obi_be_i;
  logic        obi_gnt_o, obi_rvalid_o, obi_err_o;
  logic [31:0] obi_rdata_o;
  logic        dram_cmd_valid_o, dram_cmd_ready_i, dram_cmd_we_o;
  logic [31:0] dram_cmd_addr_o, dram_cmd_wdata_o;
  logic [3:0]  dram_cmd_be_o;
  logic        dram_rsp_valid_i, dram_rsp_error_i;
  logic [31:0] dram_rsp_rdata_i;
  logic        busy_o, timeout_o;

  obi_dram_bridge #(
    .BASE_ADDR(BASE), .WINDOW_SIZE(SIZE), .MAX_OUTSTANDING(4)
`ifdef OBI_DRAM_BRIDGE_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TO)
`endif
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .obi_req_i(obi_req_i), .obi_addr_i(obi_addr_i), .obi_we_i(obi_we_i),
    .obi_be_i(obi_be_i), .obi_wdata_i(obi_wdata_i), .obi_gnt_o(obi_gnt_o),
    .obi_rvalid_o(obi_rvalid_o), .obi_rdata_o(obi_rdata_o), .obi_err_o(obi_err_o),
    .dram_cmd_valid_o(dram_cmd_valid_o), .dram_cmd_ready_i(dram_cmd_ready_i),
    .dram_cmd_addr_o(dram_cmd_addr_o), .dram_cmd_we_o(dram_cmd_we_o),
    .dram_cmd_be_o(dram_cmd_be_o), .dram_cmd_wdata_o(dram_cmd_wdata_o),
    .dram_rsp_valid_i(dram_rsp_valid_i), .dram_rsp_rdata_i(dram_rsp_rdata_i),
    .dram_rsp_error_i(dram_rsp_error_i), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  typedef struct { int due; logic [32:0] d; } rsp_t;
  logic [32:0] exp_q[$];      // {err, rdata} in grant order
  logic [68:0] exp_cmd_q[$];  // {addr, we, be, wdata} in grant order
  rsp_t        rsp_q[$];      // DRAM responses owed by the responder
  int  n_checks = 0, n_fail = 0;
  int  n_gnt = 0, n_rv = 0, gnt_cyc = 0, rv_cyc = 0, last_due = 0;
  int  n_accepted = 0, n_issued = 0;
  bit  mon_gnt = 0, mon_cmd_valid = 0, hold_rsp = 0, expect_timeout = 0;
  int  ready_mode = 0;  // 0: always ready, 1: random, 2: never ready

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference DRAM contents: reads return a function of the window offset, writes return 0.
  function automatic logic [32:0] dram_model(input logic [31:0] off, input logic we);
    logic [31:0] d;
    d = we ? 32'h0 : (32'hCAFE_0011 ^ off);
    return {off[4] & off[9], d};
  endfunction

  function automatic bit in_window(input logic [31:0] a);
    logic [32:0] lo, hi;
    lo = {1'b0, BASE};
    hi = {1'b0, BASE} + {1'b0, SIZE};
    return ({1'b0, a} >= lo) && ({1'b0, a} < hi);
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic [32:0] e;
    logic [31:0] off;
    int due;
    forever begin
      @(negedge clk);
      #4;
      mon_gnt       = obi_gnt_o;
      mon_cmd_valid = dram_cmd_valid_o;
      if (rst_ni) begin
        if (obi_rvalid_o) begin
          n_rv++;
          rv_cyc = cyc;
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL rvalid_unexpected actual=1 expected=0 (cycle %0d)", cyc);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_rdata", obi_rdata_o, e[31:0]);
            chk("rsp_err", obi_err_o, e[32]);
          end
        end
        if (dram_cmd_valid_o) begin
          if (exp_cmd_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL cmd_unexpected actual=%0h expected=none", dram_cmd_addr_o);
          end else begin
            chk("cmd_fields", {dram_cmd_addr_o, dram_cmd_we_o, dram_cmd_be_o, dram_cmd_wdata_o},
                exp_cmd_q[0]);
            if (dram_cmd_ready_i) begin
              void'(exp_cmd_q.pop_front());
              due = cyc + $urandom_range(3, 6);
              if (due < last_due + 5) due = last_due + 5;
              last_due = due;
              rsp_q.push_back('{due, dram_model(dram_cmd_addr_o, dram_cmd_we_o)});
              n_accepted++;
            end
          end
        end
        if (obi_req_i && obi_gnt_o) begin
          n_gnt++;
          gnt_cyc = cyc;
          if (in_window(obi_addr_i)) begin
            off = obi_addr_i - BASE;
            exp_cmd_q.push_back({off, obi_we_i, obi_be_i, obi_wdata_i});
            exp_q.push_back(expect_timeout ? {1'b1, 32'hDEAD_BEEF} : dram_model(off, obi_we_i));
          end else begin
            exp_q.push_back({1'b1, 32'hDEAD_BEEF});
          end
        end
      end
    end
  end

  // ---------------- DRAM responder ----------------
  initial begin
    rsp_t r;
    int zrun;
    zrun = 0;
    dram_cmd_ready_i = 1'b0; dram_rsp_valid_i = 1'b0;
    dram_rsp_rdata_i = '0;   dram_rsp_error_i = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0: dram_cmd_ready_i = 1'b1;
        1: dram_cmd_ready_i = (zrun >= 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
        default: dram_cmd_ready_i = 1'b0;
      endcase
      zrun = dram_cmd_ready_i ? 0 : zrun + 1;
      if (rst_ni && !hold_rsp && rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        r = rsp_q.pop_front();
        n_issued++;
        assert (n_issued <= n_accepted) else $error("DRAM response with no accepted command");
        dram_rsp_valid_i = 1'b1;
        dram_rsp_rdata_i = r.d[31:0];
        dram_rsp_error_i = r.d[32];
      end else begin
        dram_rsp_valid_i = 1'b0;
        dram_rsp_rdata_i = '0;
        dram_rsp_error_i = 1'b0;
      end
    end
  end

  // ---------------- OBI driver tasks ----------------
  task automatic obi_issue(input logic [31:0] a, input logic we, input logic [3:0] be,
                           input logic [31:0] wd);
    int n;
    obi_req_i = 1'b1; obi_addr_i = a; obi_we_i = we; obi_be_i = be; obi_wdata_i = wd;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!mon_gnt && n < 2000);
    if (!mon_gnt) begin
      n_checks++; n_fail++;
      $display("FAIL grant_wait actual=no_grant expected=grant addr=%0h", a);
    end
    @(negedge clk);
    obi_req_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rsp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      n_checks++; n_fail++;
      $display("FAIL drain_wait actual=%0d pending expected=0", exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n0, r0;
    logic [31:0] a;
    logic [31:0] bnd[6];
    rst_ni = 1'b0; obi_req_i = 1'b0; obi_addr_i = '0; obi_we_i = 1'b0;
    obi_be_i = '0; obi_wdata_i = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_gnt", obi_gnt_o, 0);
    chk("reset_rvalid", obi_rvalid_o, 0);
    chk("reset_cmd_valid", dram_cmd_valid_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_timeout", timeout_o, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);

    // Single read: offset 0x10 appears on the command port one cycle after grant.
    obi_issue(32'h4000_0010, 1'b0, 4'hF, 32'h0);
    #1;
    chk("single_cmd_valid", dram_cmd_valid_o, 1);
    chk("single_cmd_addr", dram_cmd_addr_o, 32'h10);
    drain();
    chk("idle_busy", busy_o, 0);

    // Six back-to-back reads with responses held: only four may be granted.
    ready_mode = 0; hold_rsp = 1; n0 = n_gnt; r0 = n_rv;
    fork
      for (int k = 0; k < 6; k++) begin
        a = BASE + 32'h100 + 32'(k * 4);
        obi_issue(a, 1'b0, 4'hF, 32'h0);
      end
      begin
        repeat (10) @(negedge clk);
        chk("b2b_grants_held", n_gnt - n0, 4);
        chk("b2b_no_rvalid_held", n_rv - r0, 0);
        hold_rsp = 0;
      end
    join
    drain();
    chk("b2b_all_answered", n_rv - r0, 6);

    // Out-of-window read queued behind a pending DRAM read must wait for it.
    hold_rsp = 1; r0 = n_rv;
    obi_issue(BASE + 32'h200, 1'b0, 4'hF, 32'h0);
    obi_issue(32'h0000_0100, 1'b0, 4'hF, 32'h0);
    repeat (4) @(negedge clk);
    chk("local_err_waits", n_rv - r0, 0);
    hold_rsp = 0;
    drain();

    // DRAM stalls: command fields hold and a second in-window request is not granted.
    ready_mode = 2;
    obi_issue(BASE + 32'h30, 1'b1, 4'b0000, 32'h1234_5678);
    fork
      obi_issue(BASE + 32'h34, 1'b0, 4'hF, 32'h0);
      begin
        repeat (5) begin
          @(posedge clk);
          chk("stall_no_gnt", mon_gnt, 0);
          chk("stall_cmd_valid", mon_cmd_valid, 1);
        end
        ready_mode = 0;
      end
    join
    drain();

    // Reset with three requests outstanding discards everything.
    hold_rsp = 1;
    for (int k = 0; k < 3; k++) begin
      a = BASE + 32'h400 + 32'(k * 4);
      obi_issue(a, 1'b0, 4'hF, 32'h0);
    end
    repeat (2) @(negedge clk);
    chk("pre_reset_busy", busy_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("mid_reset_rvalid", obi_rvalid_o, 0);
    chk("mid_reset_rdata", obi_rdata_o, 0);
    chk("mid_reset_err", obi_err_o, 0);
    chk("mid_reset_cmd", {dram_cmd_valid_o, dram_cmd_addr_o, dram_cmd_we_o, dram_cmd_be_o,
                          dram_cmd_wdata_o}, 0);
    chk("mid_reset_busy", busy_o, 0);
    exp_q.delete(); exp_cmd_q.delete(); rsp_q.delete();
    repeat (2) @(negedge clk);
    rst_ni = 1'b1; hold_rsp = 0; r0 = n_rv;
    repeat (20) @(negedge clk);
    chk("no_stale_rvalid", n_rv - r0, 0);
    chk("post_reset_busy", busy_o, 0);

`ifdef OBI_DRAM_BRIDGE_TIMEOUT_EN
    // Silent DRAM: watchdog answers with an error, then the late response is dropped.
    hold_rsp = 1; expect_timeout = 1; r0 = n_rv;
    obi_issue(BASE + 32'h40, 1'b0, 4'hF, 32'h0);
    expect_timeout = 0;
    n0 = 0;
    while (n_rv == r0 && n0 < 40) begin
      @(negedge clk);
      n0++;
    end
    chk("timeout_rvalid", n_rv - r0, 1);
    chk("timeout_latency_ok", ((rv_cyc - gnt_cyc) >= TO) && ((rv_cyc - gnt_cyc) <= TO + 1), 1);
    chk("timeout_flag", timeout_o, 1);
    hold_rsp = 0;
    repeat (15) @(negedge clk);
    chk("late_rsp_dropped", n_rv - r0, 1);
    obi_issue(BASE + 32'h44, 1'b0, 4'hF, 32'h0);
    drain();
`endif

    // Randomized traffic mixing window boundaries, out-of-window and in-window accesses.
    bnd[0] = BASE - 32'd4; bnd[1] = BASE; bnd[2] = BASE + SIZE - 32'd4;
    bnd[3] = BASE + SIZE;  bnd[4] = 32'h0; bnd[5] = 32'hFFFF_FFFC;
    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0:       a = bnd[$urandom_range(0, 5)];
        1, 2:    a = $urandom & 32'h3FFF_FFFF;
        default: a = BASE + ($urandom & (SIZE - 32'd1));
      endcase
      obi_issue(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();

`ifdef OBI_DRAM_BRIDGE_TIMEOUT_EN
    chk("final_timeout_flag", timeout_o, 1);
`else
    chk("final_timeout_flag", timeout_o, 0);
`endif
    chk("final_queues_empty", exp_q.size() + exp_cmd_q.size(), 0);
    chk("final_busy", busy_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
